// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: registered match pulse on each MSB-first occurrence of PATTERN in din.
// Define SERIAL_PATTERN_DETECTOR_COUNT_EN to compile in the saturating match_count register.
module serial_pattern_detector #(
   parameter int           W       = 4,
   parameter logic [W-1:0] PATTERN = 4'b1011,
   parameter int           OVERLAP = 1,
   parameter int           CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_valid,
   input  logic             clear,
   output logic             match,
   output logic [CNT_W-1:0] match_count
);

   localparam int FILL_W = $clog2(W + 1);

   logic [W-1:0]      hist_r;
   logic [FILL_W-1:0] fill_r;
   logic              match_r;
   logic [W-1:0]      hist_nxt_s;
   logic [FILL_W-1:0] fill_nxt_s;
   logic              match_nxt_s;
   logic [W-1:0]      hist_d_s;
   logic [FILL_W-1:0] fill_d_s;

   // Next-state history/fill and match decision for an accepted sample.
   always_comb begin
      hist_nxt_s  = {hist_r[W-2:0], din};
      fill_nxt_s  = fill_r;
      match_nxt_s = 1'b0;
      hist_d_s    = hist_r;
      fill_d_s    = fill_r;
      if (fill_r == FILL_W'(W)) begin
         fill_nxt_s = fill_r;
      end else begin
         fill_nxt_s = fill_r + FILL_W'(1);
      end
      if (din_valid) begin
         match_nxt_s = (fill_nxt_s == FILL_W'(W)) && (hist_nxt_s == PATTERN);
         // Non-overlapping mode forgets everything once a match is taken.
         if (match_nxt_s && (OVERLAP == 0)) begin
            hist_d_s = {W{1'b0}};
            fill_d_s = {FILL_W{1'b0}};
         end else begin
            hist_d_s = hist_nxt_s;
            fill_d_s = fill_nxt_s;
         end
      end else begin
         hist_d_s = hist_r;
         fill_d_s = fill_r;
      end
   end

   // History, fill and match registers; clear behaves exactly like rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         hist_r  <= {W{1'b0}};
         fill_r  <= {FILL_W{1'b0}};
         match_r <= 1'b0;
      end else if (clear) begin
         hist_r  <= {W{1'b0}};
         fill_r  <= {FILL_W{1'b0}};
         match_r <= 1'b0;
      end else begin
         hist_r  <= hist_d_s;
         fill_r  <= fill_d_s;
         match_r <= match_nxt_s;
      end
   end

   assign match = match_r;

`ifdef SERIAL_PATTERN_DETECTOR_COUNT_EN
   logic [CNT_W-1:0] cnt_r;

   // Saturating match counter; match keeps pulsing once it is full.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (clear) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (match_nxt_s && (cnt_r != {CNT_W{1'b1}})) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign match_count = cnt_r;
`else
   assign match_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Directed bench for serial_pattern_detector: three instances (overlap, no-overlap, 2-bit counter)
// share one stimulus stream; expected values are hand-computed per step.
module tb_serial_pattern_detector;

`ifdef SERIAL_PATTERN_DETECTOR_COUNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       din = 1'b0;
   logic       din_valid = 1'b0;
   logic       clear = 1'b0;
   logic       match_a, match_b, match_c;
   logic [7:0] count_a, count_b;
   logic [1:0] count_c;
   int         n_cmp = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   serial_pattern_detector #(.W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear(clear),
      .match(match_a), .match_count(count_a));

   serial_pattern_detector #(.W(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) dut_b (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear(clear),
      .match(match_b), .match_count(count_b));

   serial_pattern_detector #(.W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2)) dut_c (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear(clear),
      .match(match_c), .match_count(count_c));

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ecnt(input int n);
      return CNT_ON ? 8'(n) : 8'd0;
   endfunction

   task automatic step(input logic d, input logic v, input logic c, input logic r);
      din       = d;
      din_valid = v;
      clear     = c;
      rst       = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [6:0]  s1;
      logic [21:0] s5;
      logic        e;
      s1 = 7'b1011011;
      s5 = 22'b1011011011011011011011;

      // Reset state
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      chk("rst_match_a", {7'd0, match_a}, 8'd0);
      chk("rst_match_b", {7'd0, match_b}, 8'd0);
      chk("rst_count_a", count_a, 8'd0);
      chk("rst_count_c", {6'd0, count_c}, 8'd0);

      // Test 1/2: 1011011, overlap vs non-overlap
      for (int i = 1; i <= 7; i++) begin
         step(s1[7-i], 1'b1, 1'b0, 1'b0);
         chk($sformatf("t1_match_a_%0d", i), {7'd0, match_a}, {7'd0, (i == 4 || i == 7)});
         chk($sformatf("t2_match_b_%0d", i), {7'd0, match_b}, {7'd0, (i == 4)});
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t1_idle_match_a", {7'd0, match_a}, 8'd0);
      chk("t1_count_a", count_a, ecnt(2));
      chk("t2_count_b", count_b, ecnt(1));

      // Clear resets count
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("clr_count_a", count_a, 8'd0);
      chk("clr_match_a", {7'd0, match_a}, 8'd0);

      // Test 3: gaps with din_valid=0
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t3_b1", {7'd0, match_a}, 8'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("t3_b2", {7'd0, match_a}, 8'd0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         chk($sformatf("t3_gap_%0d", i), {7'd0, match_a}, 8'd0);
      end
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t3_b3", {7'd0, match_a}, 8'd0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t3_b4_a", {7'd0, match_a}, 8'd1);
      chk("t3_b4_b", {7'd0, match_b}, 8'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t3_after", {7'd0, match_a}, 8'd0);
      chk("t3_count_a", count_a, ecnt(1));

      // Test 4: rst mid-pattern, completing bit offered during rst is dropped
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      chk("t4_rst_match", {7'd0, match_a}, 8'd0);
      chk("t4_rst_fill", 8'(dut_a.fill_r), 8'd0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t4_match_1", {7'd0, match_a}, 8'd0);
      chk("t4_fill_1", 8'(dut_a.fill_r), 8'd1);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("t4_match_2", {7'd0, match_a}, 8'd0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t4_match_3", {7'd0, match_a}, 8'd0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t4_match_4", {7'd0, match_a}, 8'd1);
      chk("t4_count_a", count_a, ecnt(1));

      // Test 5: repeated overlapping matches, 2-bit counter saturates
      step(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 22; i++) begin
         step(s5[22-i], 1'b1, 1'b0, 1'b0);
         e = (i >= 4) && (((i - 4) % 3) == 0);
         chk($sformatf("t5_match_a_%0d", i), {7'd0, match_a}, {7'd0, e});
         chk($sformatf("t5_match_c_%0d", i), {7'd0, match_c}, {7'd0, e});
         e = (i >= 4) && (((i - 4) % 6) == 0);
         chk($sformatf("t5_match_b_%0d", i), {7'd0, match_b}, {7'd0, e});
         if (i == 13) begin
            chk("t5_count_c_mid", {6'd0, count_c}, ecnt(3));
         end else begin
            n_cmp = n_cmp;
         end
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t5_count_a", count_a, ecnt(7));
      chk("t5_count_b", count_b, ecnt(4));
      chk("t5_count_c", {6'd0, count_c}, ecnt(3));

      // Test 6: clear coincident with the completing bit
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("t6_match_a", {7'd0, match_a}, 8'd0);
      chk("t6_count_a", count_a, 8'd0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t6_next_match", {7'd0, match_a}, 8'd0);
      chk("t6_next_fill", 8'(dut_a.fill_r), 8'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
